// File: rtl/com_pulse_pacer.sv
// com_pulse_pacer: counts incoming event pulses and re-issues them as single-cycle
// pulses spaced at least GAP clocks apart, so a downstream CDC pulse synchroniser
// never sees two pulses inside one handshake round trip.
// Optional feature macro: COM_PULSE_PACER_DROP_CNT_EN adds the drop_cnt port and
// its saturating dropped-event counter.
//
// Handshake note: there is no valid/ready pair here. ipulse is a per-cycle event
// (every high cycle is one event, always sampled), and opulse is a fire-and-forget
// pulse whose spacing is the only contract with the downstream synchroniser.
module com_pulse_pacer #(
    parameter int CNT_W  = 8,
    parameter int GAP    = 8,
    parameter int DROP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ipulse,
    output logic             opulse,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             busy,
    output logic             ovf
`ifdef COM_PULSE_PACER_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX   = '1;
    localparam logic [15:0]      GAP_RELOAD = 16'(GAP - 1);
    localparam bit               MULTI_GAP  = (GAP > 1);

    // Elaboration-time guards on the parameter ranges.
    if (GAP < 1 || GAP > 65535) begin : g_gap_check
        $error("com_pulse_pacer: GAP must be in 1..65535");
    end
    if (DROP_W < 1) begin : g_drop_w_check
        $error("com_pulse_pacer: DROP_W must be >= 1");
    end

    state_t      state;
    state_t      state_next;
    logic [15:0] gap_cnt;
    logic [15:0] gap_next;
    logic        opulse_next;

    logic        gap_zero;
    logic        avail;
    logic        fire;
    logic        accept;
    logic        drop;
    logic        pend_full;

    // Decode of the event bookkeeping: clr wins over everything else.
    always_comb begin
        gap_zero  = (gap_cnt == 16'd0);
        pend_full = (pend_cnt == PEND_MAX);
        avail     = (pend_cnt != '0) | ipulse;
        fire      = avail & gap_zero & ~clr;
        accept    = ipulse & ~clr & (~pend_full | fire);
        drop      = ipulse & ~clr & pend_full & ~fire;
    end

    // Next-state logic of the pacing FSM; a running gap always completes, even under clr.
    always_comb begin
        state_next  = state;
        gap_next    = gap_cnt;
        opulse_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fire) begin
                    opulse_next = 1'b1;
                    gap_next    = GAP_RELOAD;
                    state_next  = MULTI_GAP ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (!gap_zero) begin
                    gap_next = gap_cnt - 16'd1;
                end else if (fire) begin
                    opulse_next = 1'b1;
                    gap_next    = GAP_RELOAD;
                    state_next  = MULTI_GAP ? ST_GAP : ST_IDLE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                gap_next   = 16'd0;
            end
        endcase
    end

    // Pacing FSM state, gap timer and registered output pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            gap_cnt <= 16'd0;
            opulse  <= 1'b0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_next;
            opulse  <= opulse_next;
        end
    end

    // Backlog counter: simultaneous accept and fire leave it unchanged, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt <= '0;
        end else if (clr) begin
            pend_cnt <= '0;
        end else begin
            case ({accept, fire})
                2'b10:   pend_cnt <= pend_cnt + 1'b1;
                2'b01:   pend_cnt <= pend_cnt - 1'b1;
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    // Sticky overflow flag, set whenever an event is dropped at a full backlog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

`ifdef COM_PULSE_PACER_DROP_CNT_EN
    // Saturating count of dropped events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (clr) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

    // busy looks only at registered state; the GAP state covers the final zero-count cycle.
    always_comb begin
        busy = opulse | (pend_cnt != '0) | (state == ST_GAP) | (gap_cnt != 16'd0);
    end

endmodule

// File: tb/tb_com_pulse_pacer.sv
// tb_com_pulse_pacer: three pacer instances with different CNT_W/GAP driven by the
// same stimulus, each compared every cycle against a time-stamp based reference model.
module tb_com_pulse_pacer;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic ipulse;

    logic        op0, op1, op2;
    logic [2:0]  pc0;
    logic [1:0]  pc1, pc2;
    logic        bz0, bz1, bz2;
    logic        ov0, ov1, ov2;
`ifdef COM_PULSE_PACER_DROP_CNT_EN
    logic [15:0] dc0, dc1, dc2;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, one slot per instance.
    int cw[3] = '{3, 2, 2};
    int gp[3] = '{5, 2, 1};
    int m_pend[3];
    int m_op[3];
    int m_ovf[3];
    int m_drop[3];
    int m_next[3];   // first cycle in which a new fire is permitted
    int cyc = 0;

    // clock/reset block
    always #5 clk = ~clk;

    com_pulse_pacer #(.CNT_W(3), .GAP(5), .DROP_W(16)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .ipulse(ipulse),
        .opulse(op0), .pend_cnt(pc0), .busy(bz0), .ovf(ov0)
`ifdef COM_PULSE_PACER_DROP_CNT_EN
        , .drop_cnt(dc0)
`endif
    );

    com_pulse_pacer #(.CNT_W(2), .GAP(2), .DROP_W(16)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .ipulse(ipulse),
        .opulse(op1), .pend_cnt(pc1), .busy(bz1), .ovf(ov1)
`ifdef COM_PULSE_PACER_DROP_CNT_EN
        , .drop_cnt(dc1)
`endif
    );

    com_pulse_pacer #(.CNT_W(2), .GAP(1), .DROP_W(16)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .ipulse(ipulse),
        .opulse(op2), .pend_cnt(pc2), .busy(bz2), .ovf(ov2)
`ifdef COM_PULSE_PACER_DROP_CNT_EN
        , .drop_cnt(dc2)
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = 0;
            m_op[k]   = 0;
            m_ovf[k]  = 0;
            m_drop[k] = 0;
            m_next[k] = -1;
        end
    endtask

    // One clock of the specification's rules for instance k, using absolute cycle times.
    task automatic model_step(input int k, input bit ip, input bit cl);
        int  maxp;
        bit  f;
        maxp = (1 << cw[k]) - 1;
        f = ((m_pend[k] != 0) || ip) && (cyc >= m_next[k]) && !cl;
        if (cl) begin
            m_pend[k] = 0;
            m_ovf[k]  = 0;
            m_drop[k] = 0;
        end else if (ip) begin
            if (m_pend[k] < maxp || f) begin
                if (!f) m_pend[k] = m_pend[k] + 1;
            end else begin
                m_ovf[k] = 1;
                if (m_drop[k] < 65535) m_drop[k] = m_drop[k] + 1;
            end
        end else if (f) begin
            m_pend[k] = m_pend[k] - 1;
        end
        m_op[k] = f ? 1 : 0;
        if (f) m_next[k] = cyc + gp[k];
    endtask

    task automatic cmp_inst(input int k, input logic op, input int pc, input logic bz,
                            input logic ov, input int dc);
        int exp_busy;
        exp_busy = (m_op[k] != 0 || m_pend[k] != 0 || cyc <= m_next[k]) ? 1 : 0;
        check($sformatf("opulse%0d", k), int'(op), m_op[k]);
        check($sformatf("pend_cnt%0d", k), pc, m_pend[k]);
        check($sformatf("busy%0d", k), int'(bz), exp_busy);
        check($sformatf("ovf%0d", k), int'(ov), m_ovf[k]);
`ifdef COM_PULSE_PACER_DROP_CNT_EN
        check($sformatf("drop_cnt%0d", k), dc, m_drop[k]);
`else
        if (dc != 0) check($sformatf("drop_cnt%0d", k), dc, 0);
`endif
    endtask

    task automatic compare_all();
`ifdef COM_PULSE_PACER_DROP_CNT_EN
        cmp_inst(0, op0, int'(pc0), bz0, ov0, int'(dc0));
        cmp_inst(1, op1, int'(pc1), bz1, ov1, int'(dc1));
        cmp_inst(2, op2, int'(pc2), bz2, ov2, int'(dc2));
`else
        cmp_inst(0, op0, int'(pc0), bz0, ov0, 0);
        cmp_inst(1, op1, int'(pc1), bz1, ov1, 0);
        cmp_inst(2, op2, int'(pc2), bz2, ov2, 0);
`endif
    endtask

    // driver: apply one cycle of inputs, advance the model, check after the edge
    task automatic step(input bit ip, input bit cl);
        ipulse = ip;
        clr    = cl;
        for (int k = 0; k < 3; k++) model_step(k, ip, cl);
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        clr    = 1'b0;
        ipulse = 1'b0;
        model_reset();
        #2;
        compare_all();           // async reset visible before any clock edge
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // single event, then back to idle
        idle(3);
        burst(1);
        idle(8);

        // burst building a backlog
        burst(5);
        idle(30);

        // long burst: saturation, drops, saturation with simultaneous fire
        burst(14);
        idle(45);

        // clr during a running gap, then an event right after the clr
        burst(5);
        idle(2);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        idle(10);

        // clr together with ipulse while full: the event is discarded
        burst(10);
        step(1'b1, 1'b1);
        idle(20);

        // randomized phases at increasing event density, with rare clr
        for (int p = 0; p < 3; p++) begin
            int dens;
            dens = (p == 0) ? 15 : ((p == 1) ? 50 : 90);
            for (int i = 0; i < 600; i++) begin
                step($urandom_range(99) < dens, $urandom_range(63) == 0);
            end
        end

        // async reset mid-burst, asserted between clock edges
        burst(6);
        ipulse = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        step(1'b1, 1'b0);        // bypass after reset: opulse on the next cycle
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
